// File: rtl/bs_out_wb_streamer.sv
// bs_out_wb_streamer: walks an output-buffer address range, reads every
// 8-column group of each address from the core's write-back port and
// streams the returned 64-bit words out on an AXI4-Stream master.
// Reads are only issued when the output FIFO is guaranteed to have room
// once the data returns, so arbitrary tready backpressure is safe.
module bs_out_wb_streamer #(
  parameter int ADDR_W     = 10,
  parameter int COL_GRPS   = 4,
  parameter int LEN_W      = 16,
  parameter int RD_LAT     = 2,
  parameter int FIFO_DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [LEN_W-1:0]  num_rows,
  input  logic              buf_sel,
  output logic              busy,
  output logic              done,
  output logic [2:0]        bs_out_buf_wb_en,
  output logic [ADDR_W-1:0] bs_out_buf_wb_addr,
  output logic              bs_out_buf_wb_sel,
  input  logic [63:0]       bs_out_wb_data,
  output logic [63:0]       m_axis_tdata,
  output logic              m_axis_tvalid,
  input  logic              m_axis_tready,
  output logic              m_axis_tlast
);

  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
  localparam int CRD_W = $clog2(FIFO_DEPTH + RD_LAT + 1) + 1;
  localparam logic [2:0] LAST_GRP = 3'(COL_GRPS - 1);

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    DRAIN,
    FIN
  } state_t;

  state_t              state_q, state_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic [LEN_W-1:0]    rows_q, rows_d;
  logic [LEN_W-1:0]    row_q, row_d;
  logic [2:0]          grp_q, grp_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic                sel_q, sel_d;
  logic [RD_LAT-1:0]   vld_sr_q, vld_sr_d;
  logic [RD_LAT-1:0]   lst_sr_q, lst_sr_d;
  logic [64:0]         mem_q [FIFO_DEPTH];
  logic [64:0]         mem_d [FIFO_DEPTH];
  logic [PTR_W-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]    fifo_cnt_q, fifo_cnt_d;

  logic [CRD_W-1:0]    inflight;
  logic                credit_ok;
  logic                issue;
  logic                last_issue;
  logic                fifo_push;
  logic                fifo_pop;
  logic [64:0]         head;

  // Count reads still travelling through the fixed-latency read pipe.
  always_comb begin
    inflight = '0;
    for (int i = 0; i < RD_LAT; i++) begin
      inflight = inflight + CRD_W'(vld_sr_q[i]);
    end
  end

  assign credit_ok  = (inflight + CRD_W'(fifo_cnt_q)) < CRD_W'(FIFO_DEPTH);
  assign issue      = (state_q == ISSUE) && credit_ok;
  assign last_issue = (row_q == (rows_q - LEN_W'(1))) && (grp_q == LAST_GRP);
  assign fifo_push  = vld_sr_q[RD_LAT-1];
  assign fifo_pop   = (fifo_cnt_q != '0) && m_axis_tready;
  assign head       = mem_q[rd_ptr_q];

  // Read-tracking shift register and the output FIFO bookkeeping.
  always_comb begin
    vld_sr_d    = '0;
    lst_sr_d    = '0;
    vld_sr_d[0] = issue;
    lst_sr_d[0] = issue && last_issue;
    for (int i = 1; i < RD_LAT; i++) begin
      vld_sr_d[i] = vld_sr_q[i-1];
      lst_sr_d[i] = lst_sr_q[i-1];
    end

    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (fifo_push) begin
      mem_d[wr_ptr_q] = {lst_sr_q[RD_LAT-1], bs_out_wb_data};
      wr_ptr_d        = wr_ptr_q + PTR_W'(1);
    end
    if (fifo_pop) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end

    fifo_cnt_d = fifo_cnt_q;
    if (fifo_push && !fifo_pop) begin
      fifo_cnt_d = fifo_cnt_q + CNT_W'(1);
    end else if (!fifo_push && fifo_pop) begin
      fifo_cnt_d = fifo_cnt_q - CNT_W'(1);
    end
  end

  // Job sequencing: launch, row-major issue walk, drain and completion.
  always_comb begin
    state_d = state_q;
    busy_d  = done_q ? 1'b0 : busy_q;
    done_d  = 1'b0;
    rows_d  = rows_q;
    row_d   = row_q;
    grp_d   = grp_q;
    addr_d  = addr_q;
    sel_d   = sel_q;

    case (state_q)
      IDLE: begin
        if (start) begin
          rows_d  = num_rows;
          row_d   = '0;
          grp_d   = '0;
          addr_d  = base_addr;
          sel_d   = buf_sel;
          busy_d  = 1'b1;
          state_d = (num_rows != '0) ? ISSUE : FIN;
        end
      end
      ISSUE: begin
        if (issue) begin
          if (last_issue) begin
            state_d = DRAIN;
          end else if (grp_q == LAST_GRP) begin
            grp_d  = '0;
            row_d  = row_q + LEN_W'(1);
            addr_d = addr_q + ADDR_W'(1);
          end else begin
            grp_d = grp_q + 3'd1;
          end
        end
      end
      DRAIN: begin
        // The final beat leaving the FIFO ends the job; done is raised
        // right away so it lands in the cycle after that handshake.
        if (fifo_pop && head[64] && (inflight == '0)) begin
          state_d = FIN;
          done_d  = 1'b1;
        end else if ((inflight == '0) && (fifo_cnt_q == '0)) begin
          state_d = FIN;
        end
      end
      FIN: begin
        // Raise done here only if the drain path has not already done so.
        done_d  = !done_q;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // All state and registered outputs, with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      rows_q     <= '0;
      row_q      <= '0;
      grp_q      <= '0;
      addr_q     <= '0;
      sel_q      <= 1'b0;
      vld_sr_q   <= '0;
      lst_sr_q   <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      fifo_cnt_q <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      state_q    <= state_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      rows_q     <= rows_d;
      row_q      <= row_d;
      grp_q      <= grp_d;
      addr_q     <= addr_d;
      sel_q      <= sel_d;
      vld_sr_q   <= vld_sr_d;
      lst_sr_q   <= lst_sr_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      fifo_cnt_q <= fifo_cnt_d;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        mem_q[i] <= mem_d[i];
      end
    end
  end

  assign busy               = busy_q;
  assign done               = done_q;
  assign bs_out_buf_wb_en   = grp_q;
  assign bs_out_buf_wb_addr = addr_q;
  assign bs_out_buf_wb_sel  = sel_q;
  assign m_axis_tvalid      = (fifo_cnt_q != '0);
  assign m_axis_tdata       = head[63:0];
  assign m_axis_tlast       = m_axis_tvalid && head[64];

endmodule

// File: tb/tb_bs_out_wb_streamer.sv
// tb_bs_out_wb_streamer: table-driven jobs against a fixed-latency core
// read model, plus hand-written reset sequences.
module tb_bs_out_wb_streamer;

  localparam int ADDR_W = 10;
  localparam int GRPS   = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [9:0]  base_addr = '0;
  logic [15:0] num_rows = '0;
  logic        buf_sel = 1'b0;
  logic        busy, done;
  logic [2:0]  wb_en;
  logic [9:0]  wb_addr;
  logic        wb_sel;
  logic [63:0] wb_data;
  logic [63:0] tdata;
  logic        tvalid;
  logic        tready = 1'b1;
  logic        tlast;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int ready_mode = 0;

  logic [64:0] beat_q[$];
  int          hs_cyc_q[$];
  int          done_cnt = 0;
  int          done_cyc = 0;
  int          busy_cnt = 0;
  int          stall_err = 0;
  int          ovf_cnt = 0;
  logic        prev_stall = 1'b0;
  logic [64:0] prev_beat = '0;

  logic [13:0] rd_p0 = '0;
  logic [13:0] rd_p1 = '0;

  typedef struct {
    logic [9:0]  base;
    logic [15:0] rows;
    logic        sel;
    int          mode;
    int          intrude;
    int          exp_beats;
    logic [9:0]  exp_last_addr;
  } vec_t;

  vec_t vecs[6];

  bs_out_wb_streamer dut (
    .clk                (clk),
    .rst_n              (rst_n),
    .start              (start),
    .base_addr          (base_addr),
    .num_rows           (num_rows),
    .buf_sel            (buf_sel),
    .busy               (busy),
    .done               (done),
    .bs_out_buf_wb_en   (wb_en),
    .bs_out_buf_wb_addr (wb_addr),
    .bs_out_buf_wb_sel  (wb_sel),
    .bs_out_wb_data     (wb_data),
    .m_axis_tdata       (tdata),
    .m_axis_tvalid      (tvalid),
    .m_axis_tready      (tready),
    .m_axis_tlast       (tlast)
  );

  always #5 clk = ~clk;

  // Cycle counter used to timestamp events.
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [63:0] make_word(input logic sel, input logic [9:0] addr,
                                            input logic [2:0] g);
    return {31'h0, sel, 6'h0, addr, 13'h0, g};
  endfunction

  function automatic logic [63:0] exp_word(input logic [9:0] base, input int k,
                                           input logic sel);
    int row;
    logic [9:0] a;
    row = k / GRPS;
    a = 10'((int'(base) + row) % 1024);
    return make_word(sel, a, 3'(k % GRPS));
  endfunction

  // Core read model: data for a read appears two cycles after its issue.
  always @(posedge clk) begin
    rd_p0 <= {wb_sel, wb_addr, wb_en};
    rd_p1 <= rd_p0;
  end
  assign wb_data = make_word(rd_p1[13], rd_p1[12:3], rd_p1[2:0]);

  // Downstream ready: always ready, or roughly 30% duty.
  always @(posedge clk) begin
    #1;
    if (ready_mode == 1) tready = ($urandom_range(0, 9) < 3);
    else tready = 1'b1;
  end

  // Stream monitor sampling on the falling edge.
  always @(negedge clk) begin
    if (!rst_n) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall && (!tvalid || ({tlast, tdata} != prev_beat))) stall_err++;
      if (tvalid && tready) begin
        beat_q.push_back({tlast, tdata});
        hs_cyc_q.push_back(cyc);
      end
      if (dut.fifo_push && !dut.fifo_pop && (int'(dut.fifo_cnt_q) == 4)) ovf_cnt++;
      prev_stall = tvalid && !tready;
      prev_beat  = {tlast, tdata};
    end
    if (done) begin
      done_cnt++;
      done_cyc = cyc;
    end
    if (busy) busy_cnt++;
  end

  task automatic check_output(input string name, input logic [64:0] actual,
                              input logic [64:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, actual, expected);
    end
  endtask

  task automatic apply_stimulus(input vec_t v);
    int b0, d0, bz0, s0, o0, start_cyc, n, waited;
    logic [64:0] e;
    ready_mode = v.mode;
    @(posedge clk); #1;
    b0 = beat_q.size(); d0 = done_cnt; bz0 = busy_cnt; s0 = stall_err; o0 = ovf_cnt;
    start = 1'b1; base_addr = v.base; num_rows = v.rows; buf_sel = v.sel;
    start_cyc = cyc;
    @(posedge clk); #1;
    start = 1'b0; base_addr = 10'h2AA; num_rows = 16'd9; buf_sel = ~v.sel;
    if (v.intrude != 0) begin
      @(posedge clk); #1;
      start = 1'b1; base_addr = 10'd500; num_rows = 16'd7; buf_sel = ~v.sel;
      @(posedge clk); #1;
      start = 1'b0;
    end
    waited = 0;
    while (done_cnt == d0 && waited < 2000) begin
      @(negedge clk);
      waited++;
    end
    repeat (4) @(negedge clk);
    check_output("done_count", 65'(done_cnt - d0), 65'd1);
    n = beat_q.size() - b0;
    check_output("beat_count", 65'(n), 65'(v.exp_beats));
    for (int k = 0; k < n && k < v.exp_beats; k++) begin
      e = {(k == v.exp_beats - 1), exp_word(v.base, k, v.sel)};
      check_output("beat_data", beat_q[b0 + k], e);
    end
    if (v.exp_beats > 0) begin
      if (n > 0) begin
        check_output("last_addr", 65'(beat_q[b0 + n - 1][25:16]), 65'(v.exp_last_addr));
        check_output("done_after_last", 65'(done_cyc), 65'(hs_cyc_q[b0 + n - 1] + 1));
        if (v.mode == 0) begin
          check_output("first_valid_lat", 65'(hs_cyc_q[b0] - start_cyc), 65'd4);
          check_output("no_bubbles", 65'(hs_cyc_q[b0 + n - 1] - hs_cyc_q[b0]), 65'(n - 1));
        end
      end
    end else begin
      check_output("zero_done_lat", 65'(done_cyc - start_cyc), 65'd2);
      check_output("zero_busy_len", 65'(busy_cnt - bz0), 65'd2);
    end
    check_output("busy_len", 65'(busy_cnt - bz0), 65'(done_cyc - start_cyc));
    check_output("stall_stable", 65'(stall_err - s0), 65'd0);
    check_output("fifo_overflow", 65'(ovf_cnt - o0), 65'd0);
  endtask

  task automatic check_reset_outputs(input string tag);
    check_output({tag, "_busy"}, 65'(busy), 65'd0);
    check_output({tag, "_done"}, 65'(done), 65'd0);
    check_output({tag, "_tvalid"}, 65'(tvalid), 65'd0);
    check_output({tag, "_tlast"}, 65'(tlast), 65'd0);
    check_output({tag, "_tdata"}, 65'(tdata), 65'd0);
    check_output({tag, "_wb_en"}, 65'(wb_en), 65'd0);
    check_output({tag, "_wb_addr"}, 65'(wb_addr), 65'd0);
    check_output({tag, "_wb_sel"}, 65'(wb_sel), 65'd0);
  endtask

  initial begin
    int b0, d0, waited;
    vec_t after_rst;
    vecs[0] = '{10'd5,    16'd1, 1'b0, 0, 0, 4,  10'd5};
    vecs[1] = '{10'd0,    16'd8, 1'b1, 1, 0, 32, 10'd7};
    vecs[2] = '{10'd1022, 16'd4, 1'b0, 0, 0, 16, 10'd1};
    vecs[3] = '{10'd1023, 16'd3, 1'b1, 1, 0, 12, 10'd1};
    vecs[4] = '{10'd10,   16'd3, 1'b1, 0, 1, 12, 10'd12};
    vecs[5] = '{10'd77,   16'd0, 1'b0, 0, 0, 0,  10'd0};

    $display("[TB] reset state");
    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    @(posedge clk); #1;
    rst_n = 1'b1;

    for (int i = 0; i < 6; i++) begin
      $display("[TB] vector %0d base=%0d rows=%0d", i, vecs[i].base, vecs[i].rows);
      apply_stimulus(vecs[i]);
    end

    $display("[TB] reset mid-job");
    ready_mode = 0;
    @(posedge clk); #1;
    b0 = beat_q.size(); d0 = done_cnt;
    start = 1'b1; base_addr = 10'd200; num_rows = 16'd16; buf_sel = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    waited = 0;
    while ((beat_q.size() - b0) < 5 && waited < 200) begin
      @(negedge clk);
      waited++;
    end
    check_output("mid_beats_seen", 65'((beat_q.size() - b0) >= 5), 65'd1);
    @(posedge clk); #1;
    rst_n = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check_reset_outputs("midrst");
    @(posedge clk); #1;
    rst_n = 1'b1;
    b0 = beat_q.size();
    repeat (10) @(negedge clk);
    check_output("midrst_no_done", 65'(done_cnt - d0), 65'd0);
    check_output("midrst_no_beats", 65'(beat_q.size() - b0), 65'd0);
    after_rst = '{10'd900, 16'd2, 1'b0, 0, 0, 8, 10'd901};
    apply_stimulus(after_rst);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
